// File: rtl/miner_pkg.sv
// Shared constants, channel FSM state type and byte-reverse helper for msg_loader.
// Byte reversal is used only when MSG_LOADER_BYTE_SWAP_EN is defined.
package miner_pkg;

    localparam int WORD_W       = 32;
    localparam int MSG_WORDS    = 19;
    localparam int TARGET_WORDS = 8;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } chan_state_e;

    function automatic logic [WORD_W-1:0] byte_rev(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/word_shift_buf.sv
// One loader channel: a left-shifting word buffer with a word count and a FILL/PEND handshake FSM.
module word_shift_buf
    import miner_pkg::*;
#(
    parameter int WORDS = 8,
    parameter int CNT_W = $clog2(WORDS + 1)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      clear_i,
    input  logic                      wr_en_i,
    input  logic [WORD_W-1:0]         wr_data_i,
    input  logic                      ack_i,
    output logic [WORDS*WORD_W-1:0]   data_o,
    output logic [CNT_W-1:0]          count_o,
    output logic                      pend_o,
    output logic                      overrun_o
);

    localparam int BUF_W = WORDS * WORD_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    chan_state_e        state_q, state_d;
    logic [BUF_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovr_q, ovr_d;
    logic [BUF_W-1:0]   shifted;

    // Oldest word drifts toward the MSBs, so word 0 ends up on top once the block is full.
    assign shifted = {data_q[BUF_W-WORD_W-1:0], wr_data_i};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        ovr_d   = 1'b0;
        if (clear_i) begin
            state_d = ST_FILL;
            count_d = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (wr_en_i) begin
                        data_d  = shifted;
                        count_d = count_q + ONE;
                        if (count_q == LAST) state_d = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (ack_i) begin
                        // A write landing with the acknowledge starts the next block.
                        state_d = ST_FILL;
                        if (wr_en_i) begin
                            data_d  = shifted;
                            count_d = ONE;
                        end else begin
                            count_d = '0;
                        end
                    end else if (wr_en_i) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_FILL;
            data_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign count_o   = count_q;
    assign pend_o    = (state_q == ST_PEND);
    assign overrun_o = ovr_q;

endmodule

// File: rtl/msg_loader.sv
// Host-to-controller loader for a 19-word message block and an 8-word target.
// Define MSG_LOADER_BYTE_SWAP_EN to byte-reverse every host word before storage.
module msg_loader
    import miner_pkg::*;
(
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          wr_en,
    input  logic                          wr_sel,
    input  logic [WORD_W-1:0]             wr_data,
    input  logic                          clear,
    input  logic                          loadMsg,
    input  logic                          loadTarget,
    output logic                          newMsg,
    output logic                          newTarget,
    output logic [MSG_WORDS*WORD_W-1:0]   msg_block,
    output logic [TARGET_WORDS*WORD_W-1:0] target,
    output logic [4:0]                    msg_count,
    output logic [3:0]                    target_count,
    output logic                          overrun
);

    logic [WORD_W-1:0] word_in;
    logic              msg_ovr, tgt_ovr;

`ifdef MSG_LOADER_BYTE_SWAP_EN
    assign word_in = byte_rev(wr_data);
`else
    assign word_in = wr_data;
`endif

    word_shift_buf #(
        .WORDS (MSG_WORDS),
        .CNT_W (5)
    ) u_msg (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear_i   (clear),
        .wr_en_i   (wr_en && !wr_sel),
        .wr_data_i (word_in),
        .ack_i     (loadMsg),
        .data_o    (msg_block),
        .count_o   (msg_count),
        .pend_o    (newMsg),
        .overrun_o (msg_ovr)
    );

    word_shift_buf #(
        .WORDS (TARGET_WORDS),
        .CNT_W (4)
    ) u_tgt (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear_i   (clear),
        .wr_en_i   (wr_en && wr_sel),
        .wr_data_i (word_in),
        .ack_i     (loadTarget),
        .data_o    (target),
        .count_o   (target_count),
        .pend_o    (newTarget),
        .overrun_o (tgt_ovr)
    );

    // Only one channel can be written per cycle, so at most one source pulses.
    assign overrun = msg_ovr | tgt_ovr;

endmodule

// File: tb/tb_msg_loader.sv
// Self-checking bench for msg_loader: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_msg_loader;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         wr_en = 1'b0;
    logic         wr_sel = 1'b0;
    logic [31:0]  wr_data = '0;
    logic         clear = 1'b0;
    logic         loadMsg = 1'b0;
    logic         loadTarget = 1'b0;
    logic         newMsg, newTarget, overrun;
    logic [607:0] msg_block;
    logic [255:0] target;
    logic [4:0]   msg_count;
    logic [3:0]   target_count;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: each channel holds the last N stored words, oldest at the front.
    logic [31:0] mq[$];
    logic [31:0] tq[$];
    int          m_cnt, t_cnt;
    bit          m_pend, t_pend, ovr_exp;

    msg_loader dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .clear        (clear),
        .loadMsg      (loadMsg),
        .loadTarget   (loadTarget),
        .newMsg       (newMsg),
        .newTarget    (newTarget),
        .msg_block    (msg_block),
        .target       (target),
        .msg_count    (msg_count),
        .target_count (target_count),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef MSG_LOADER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [607:0] exp_msg();
        logic [607:0] v;
        v = '0;
        for (int i = 0; i < 19; i++) v[607-32*i -: 32] = mq[i];
        return v;
    endfunction

    function automatic logic [255:0] exp_tgt();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[255-32*i -: 32] = tq[i];
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        tq.delete();
        for (int i = 0; i < 19; i++) mq.push_back(32'h0);
        for (int i = 0; i < 8; i++) tq.push_back(32'h0);
        m_cnt = 0; t_cnt = 0; m_pend = 0; t_pend = 0; ovr_exp = 0;
    endtask

    task automatic model_step();
        bit wm, wt;
        wm = wr_en && !wr_sel;
        wt = wr_en && wr_sel;
        ovr_exp = 0;
        if (clear) begin
            m_cnt = 0; m_pend = 0; t_cnt = 0; t_pend = 0;
        end else begin
            if (m_pend) begin
                if (loadMsg) begin
                    m_pend = 0;
                    m_cnt = 0;
                    if (wm) begin
                        mq.push_back(stored(wr_data)); void'(mq.pop_front()); m_cnt = 1;
                    end
                end else if (wm) ovr_exp = 1;
            end else if (wm) begin
                mq.push_back(stored(wr_data)); void'(mq.pop_front());
                m_cnt++;
                if (m_cnt == 19) m_pend = 1;
            end
            if (t_pend) begin
                if (loadTarget) begin
                    t_pend = 0;
                    t_cnt = 0;
                    if (wt) begin
                        tq.push_back(stored(wr_data)); void'(tq.pop_front()); t_cnt = 1;
                    end
                end else if (wt) ovr_exp = 1;
            end else if (wt) begin
                tq.push_back(stored(wr_data)); void'(tq.pop_front());
                t_cnt++;
                if (t_cnt == 8) t_pend = 1;
            end
        end
    endtask

    task automatic cyc(input logic we, input logic sel, input logic [31:0] d,
                       input logic clr, input logic lm, input logic lt);
        wr_en = we; wr_sel = sel; wr_data = d; clear = clr; loadMsg = lm; loadTarget = lt;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        wr_en = 0; wr_sel = 0; wr_data = '0; clear = 0; loadMsg = 0; loadTarget = 0;
        n_rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (newMsg !== 1'b0) begin n_fail++; $display("FAIL reset_newMsg got=%b want=0", newMsg); end
        n_cmp++; if (newTarget !== 1'b0) begin n_fail++; $display("FAIL reset_newTarget got=%b want=0", newTarget); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        n_cmp++; if (msg_count !== 5'd0) begin n_fail++; $display("FAIL reset_msg_count got=%0d want=0", msg_count); end
        n_cmp++; if (target_count !== 4'd0) begin n_fail++; $display("FAIL reset_target_count got=%0d want=0", target_count); end
        n_cmp++; if (msg_block !== '0) begin n_fail++; $display("FAIL reset_msg_block got=%h want=0", msg_block); end
        n_cmp++; if (target !== '0) begin n_fail++; $display("FAIL reset_target got=%h want=0", target); end
    endtask

    task automatic test_target_fill();
        logic [255:0] exp;
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            exp[255-32*i -: 32] = stored(32'(i));
            if (i == 6) begin
                n_cmp++; if (newTarget !== 1'b0) begin n_fail++; $display("FAIL tgt_early_newTarget got=%b want=0", newTarget); end
                n_cmp++; if (target_count !== 4'd7) begin n_fail++; $display("FAIL tgt_count7 got=%0d want=7", target_count); end
            end
        end
        n_cmp++; if (newTarget !== 1'b1) begin n_fail++; $display("FAIL tgt_newTarget got=%b want=1", newTarget); end
        n_cmp++; if (target_count !== 4'd8) begin n_fail++; $display("FAIL tgt_count8 got=%0d want=8", target_count); end
        n_cmp++; if (target !== exp) begin n_fail++; $display("FAIL tgt_words got=%h want=%h", target, exp); end
        idle();
        n_cmp++; if (newTarget !== 1'b1) begin n_fail++; $display("FAIL tgt_hold_newTarget got=%b want=1", newTarget); end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (newTarget !== 1'b0) begin n_fail++; $display("FAIL tgt_ack_newTarget got=%b want=0", newTarget); end
        n_cmp++; if (target_count !== 4'd0) begin n_fail++; $display("FAIL tgt_ack_count got=%0d want=0", target_count); end
        n_cmp++; if (target !== exp) begin n_fail++; $display("FAIL tgt_ack_hold got=%h want=%h", target, exp); end
    endtask

    task automatic fill_msg(output logic [607:0] exp);
        exp = '0;
        for (int i = 0; i < 19; i++) begin
            cyc(1'b1, 1'b0, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
            exp[607-32*i -: 32] = stored(32'hA000_0000 + 32'(i));
        end
    endtask

    task automatic test_msg_fill_ack();
        logic [607:0] exp;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (newMsg !== 1'b0) begin n_fail++; $display("FAIL msg_ack_in_fill got=%b want=0", newMsg); end
        fill_msg(exp);
        n_cmp++; if (newMsg !== 1'b1) begin n_fail++; $display("FAIL msg_newMsg got=%b want=1", newMsg); end
        n_cmp++; if (msg_count !== 5'd19) begin n_fail++; $display("FAIL msg_count19 got=%0d want=19", msg_count); end
        n_cmp++; if (msg_block !== exp) begin n_fail++; $display("FAIL msg_words got=%h want=%h", msg_block, exp); end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (newMsg !== 1'b0) begin n_fail++; $display("FAIL msg_ack_newMsg got=%b want=0", newMsg); end
        n_cmp++; if (msg_count !== 5'd0) begin n_fail++; $display("FAIL msg_ack_count got=%0d want=0", msg_count); end
        n_cmp++; if (msg_block !== exp) begin n_fail++; $display("FAIL msg_ack_hold got=%h want=%h", msg_block, exp); end
    endtask

    task automatic test_overrun_and_ack_write();
        logic [607:0] exp;
        fill_msg(exp);
        cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got=%b want=1", overrun); end
        n_cmp++; if (msg_block !== exp) begin n_fail++; $display("FAIL ovr_block got=%h want=%h", msg_block, exp); end
        n_cmp++; if (msg_count !== 5'd19) begin n_fail++; $display("FAIL ovr_count got=%0d want=19", msg_count); end
        idle();
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle got=%b want=0", overrun); end
        n_cmp++; if (newMsg !== 1'b1) begin n_fail++; $display("FAIL ovr_newMsg got=%b want=1", newMsg); end
        cyc(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (msg_count !== 5'd1) begin n_fail++; $display("FAIL ackwr_count got=%0d want=1", msg_count); end
        n_cmp++; if (msg_block[31:0] !== stored(32'h1234_5678)) begin n_fail++; $display("FAIL ackwr_low got=%h want=%h", msg_block[31:0], stored(32'h1234_5678)); end
        n_cmp++; if (msg_block[63:32] !== stored(32'hA000_0012)) begin n_fail++; $display("FAIL ackwr_shift got=%h want=%h", msg_block[63:32], stored(32'hA000_0012)); end
        n_cmp++; if (newMsg !== 1'b0) begin n_fail++; $display("FAIL ackwr_newMsg got=%b want=0", newMsg); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ackwr_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_clear_reset();
        logic [607:0] snap;
        logic [607:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h7777_0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (msg_count !== 5'd5) begin n_fail++; $display("FAIL clr_pre_count got=%0d want=5", msg_count); end
        snap = msg_block;
        cyc(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (msg_count !== 5'd0) begin n_fail++; $display("FAIL clr_msg_count got=%0d want=0", msg_count); end
        n_cmp++; if (target_count !== 4'd0) begin n_fail++; $display("FAIL clr_tgt_count got=%0d want=0", target_count); end
        n_cmp++; if (msg_block !== snap) begin n_fail++; $display("FAIL clr_hold got=%h want=%h", msg_block, snap); end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        #3;
        n_rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (msg_count !== 5'd0) begin n_fail++; $display("FAIL arst_count got=%0d want=0", msg_count); end
        n_cmp++; if (msg_block !== '0) begin n_fail++; $display("FAIL arst_block got=%h want=0", msg_block); end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc(1'b1, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
        exp = '0;
        exp[31:0] = stored(32'hCAFE_0001);
        n_cmp++; if (msg_count !== 5'd1) begin n_fail++; $display("FAIL post_rst_count got=%0d want=1", msg_count); end
        n_cmp++; if (msg_block !== exp) begin n_fail++; $display("FAIL post_rst_word0 got=%h want=%h", msg_block, exp); end
    endtask

    task automatic test_byte_swap();
        logic [31:0] want;
`ifdef MSG_LOADER_BYTE_SWAP_EN
        want = 32'h4433_2211;
`else
        want = 32'h1122_3344;
`endif
        cyc(1'b1, 1'b0, 32'h1122_3344, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (msg_block[31:0] !== want) begin n_fail++; $display("FAIL byte_order got=%h want=%h", msg_block[31:0], want); end
    endtask

    task automatic test_random();
        logic we, sel, clr, lm, lt;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            we  = ($urandom_range(0, 99) < 70);
            sel = $urandom_range(0, 1) == 1;
            clr = ($urandom_range(0, 99) < 3);
            lm  = ($urandom_range(0, 99) < 15);
            lt  = ($urandom_range(0, 99) < 15);
            cyc(we, sel, $urandom, clr, lm, lt);
            n_cmp++; if (newMsg !== m_pend) begin n_fail++; $display("FAIL rnd_newMsg c=%0d got=%b want=%b", c, newMsg, m_pend); end
            n_cmp++; if (newTarget !== t_pend) begin n_fail++; $display("FAIL rnd_newTarget c=%0d got=%b want=%b", c, newTarget, t_pend); end
            n_cmp++; if (msg_count !== 5'(m_cnt)) begin n_fail++; $display("FAIL rnd_msg_count c=%0d got=%0d want=%0d", c, msg_count, m_cnt); end
            n_cmp++; if (target_count !== 4'(t_cnt)) begin n_fail++; $display("FAIL rnd_target_count c=%0d got=%0d want=%0d", c, target_count, t_cnt); end
            n_cmp++; if (overrun !== ovr_exp) begin n_fail++; $display("FAIL rnd_overrun c=%0d got=%b want=%b", c, overrun, ovr_exp); end
            n_cmp++; if (msg_block !== exp_msg()) begin n_fail++; $display("FAIL rnd_msg_block c=%0d got=%h want=%h", c, msg_block[255:0], exp_msg() >> 0); end
            n_cmp++; if (target !== exp_tgt()) begin n_fail++; $display("FAIL rnd_target c=%0d got=%h want=%h", c, target, exp_tgt()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_target_fill();
        test_msg_fill_ack();
        test_overrun_and_ack_write();
        test_clear_reset();
        test_byte_swap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/msg_loader.md
MSG_LOADER -- requirements
Module: msg_loader

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: n_rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: wr_en  in  1  host word-write strobe, one word per cycle high.
REQ-004 SHALL have ports: wr_sel  in  1  write destination, 0 = message channel, 1 = target channel.
REQ-005 SHALL have ports: wr_data  in  32  host write word.
REQ-006 SHALL have ports: clear  in  1  synchronous abort of both channels.
REQ-007 SHALL have ports: loadMsg  in  1  controller acknowledge of message block.
REQ-008 SHALL have ports: loadTarget  in  1  controller acknowledge of target.
REQ-009 SHALL have ports: newMsg  out  1  message block complete, awaiting loadMsg.
REQ-010 SHALL have ports: newTarget  out  1  target complete, awaiting loadTarget.
REQ-011 SHALL have ports: msg_block  out  608  19 header words (nonce excluded), word 0 in bits [607:576].
REQ-012 SHALL have ports: target  out  256  8 target words, word 0 in bits [255:224].
REQ-013 SHALL have ports: msg_count  out  5  message words held (0..19).
REQ-014 SHALL have ports: target_count  out  4  target words held (0..8).
REQ-015 SHALL have ports: overrun  out  1  one-cycle pulse, write dropped.

Function
REQ-016 Each channel SHALL run an independent two-state FSM: FILL, PEND.
REQ-017 In FILL, an accepted write SHALL shift its buffer left by 32 and place wr_data in the low word, and SHALL increment that channel's count.
REQ-018 A write that makes msg_count 19 SHALL move the message FSM to PEND; newMsg SHALL be high from the next cycle.
REQ-019 A write that makes target_count 8 SHALL move the target FSM to PEND; newTarget SHALL be high from the next cycle.
REQ-020 In PEND, newMsg/newTarget SHALL stay high until the matching acknowledge is sampled high.
REQ-021 On acknowledge in PEND, the FSM SHALL return to FILL, the count SHALL clear to 0, and the buffer SHALL hold its contents.
REQ-022 Acknowledge in FILL SHALL be ignored.
REQ-023 A write to a channel in PEND without its acknowledge in the same cycle SHALL be dropped, and overrun SHALL pulse for one cycle.
REQ-024 A write coinciding with its channel's acknowledge SHALL be accepted as word 0 of the next block (count becomes 1).
REQ-025 clear SHALL force both FSMs to FILL and both counts to 0, overriding writes and acknowledges; buffers SHALL hold.
REQ-026 The outputs msg_block and target SHALL be direct register outputs, stable while PEND.

Reset
REQ-027 n_rst low SHALL asynchronously set: both FSMs to FILL; newMsg, newTarget, and overrun to 0; counts to 0; msg_block and target to all zeros.
REQ-028 Reset mid-fill SHALL discard partial words; the first write after release SHALL be word 0.

Configuration
REQ-029 With macro MSG_LOADER_BYTE_SWAP_EN defined, each wr_data word SHALL be byte-reversed before storage (e.g. 0x11223344 stored as 0x44332211).
REQ-030 Without MSG_LOADER_BYTE_SWAP_EN, words SHALL be stored unmodified.

Structure
REQ-031 A shared package miner_pkg SHALL hold the MSG_WORDS=19 and TARGET_WORDS=8 constants and the channel FSM state enum.
REQ-032 One sub-module, word_shift_buf (parameterised word count, shift-in, count, FSM), SHALL be instantiated once per channel.

Verification
REQ-033 After reset: write target words 0x00000000..0x00000007 -> newTarget rises the cycle after the 8th write; target = words in order; target_count=8.
REQ-034 Write 19 message words 0xA0000000+i -> newMsg high; pulse loadMsg -> next cycle newMsg=0, msg_count=0, msg_block unchanged.
REQ-035 With newMsg pending, write 0xDEADBEEF to message without ack -> overrun pulses 1 cycle; msg_block unchanged; msg_count=19.
REQ-036 With newMsg pending, write 0x12345678 concurrent with loadMsg -> msg_count=1, low word 0x12345678, newMsg=0.
REQ-037 After 5 message writes, assert clear, then n_rst mid-fill -> counts 0; after reset msg_block all zeros; next write lands as word 0.
REQ-038 With MSG_LOADER_BYTE_SWAP_EN, write 0x11223344 -> stored low word 0x44332211.
